// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types and constants for the cache-line memory arbiter.
// A line moves over the memory port as LINE_BITS/BEAT_BITS beats.
package cacheline_mem_arbiter_pkg;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam logic [1:0] LAST_BEAT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    DONE
  } state_e;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_e;

  function automatic logic [BEAT_BITS-1:0] line_slice(
    input logic [LINE_BITS-1:0] line,
    input logic [1:0]           k
  );
    return line[int'(k)*BEAT_BITS +: BEAT_BITS];
  endfunction

endpackage

// File: rtl/cacheline_mem_arbiter.sv
// Round-robin arbiter sharing one burst-memory port between icache and dcache.
// One line transaction at a time; every output is driven from registered state.
module cacheline_mem_arbiter
  import cacheline_mem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_read,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic [31:0]          d_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  state_e               state;
  req_id_e              owner;
  req_id_e              last_grant;
  logic [1:0]           beat;
  logic [LINE_BITS-1:0] line_buf;

  logic        any_req;
  logic        grant_d;
  logic        grant_write;
  logic [31:0] grant_addr;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    any_req     = i_read | d_read | d_write;
    grant_d     = (d_read | d_write) & (~i_read | (last_grant == REQ_I));
    grant_write = grant_d & d_write;
    grant_addr  = grant_d ? {d_addr[31:5], 5'b0} : {i_addr[31:5], 5'b0};
  end

  // The line buffer doubles as read assembly area and write source.
  assign i_rdata = line_buf;
  assign d_rdata = line_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= REQ_I;
      last_grant <= REQ_I;
      beat       <= 2'd0;
      line_buf   <= '0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= grant_d ? REQ_D : REQ_I;
            last_grant <= grant_d ? REQ_D : REQ_I;
            bmem_addr  <= grant_addr;
            beat       <= 2'd0;
            if (grant_write) begin
              line_buf   <= d_wdata;
              bmem_wdata <= d_wdata[BEAT_BITS-1:0];
              bmem_write <= 1'b1;
              state      <= WR_BURST;
            end else begin
              bmem_read <= 1'b1;
              state     <= RD_ISSUE;
            end
          end
        end

        RD_ISSUE: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            beat      <= 2'd0;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bmem_rvalid) begin
            line_buf[int'(beat)*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
            beat <= beat + 2'd1;
            if (beat == LAST_BEAT) begin
              bmem_addr <= '0;
              i_resp    <= (owner == REQ_I);
              d_resp    <= (owner == REQ_D);
              state     <= DONE;
            end
          end
        end

        // Next slice is presented only once memory takes the current one.
        WR_BURST: begin
          if (bmem_ready) begin
            beat <= beat + 2'd1;
            if (beat == LAST_BEAT) begin
              bmem_write <= 1'b0;
              bmem_wdata <= '0;
              bmem_addr  <= '0;
              i_resp     <= (owner == REQ_I);
              d_resp     <= (owner == REQ_D);
              state      <= DONE;
            end else begin
              bmem_wdata <= line_slice(line_buf, beat + 2'd1);
            end
          end
        end

        DONE: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
